uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Sequencer between the UART receiver/transmitter pair and the combinational ALU. It collects three received bytes (operand A, operand B, opcode) from the RX path and drives them onto the ALU. It then captures the ALU result and hands it to the TX path as a one-cycle `tx_start` request, and waits for `tx_done_tick` before accepting the next frame. It replaces the direct RX→TX echo wiring in the UART top level.

## Interface
- `NBIT_DATA`, 8: UART byte width, also the ALU operand/result width.
- `NBIT_OP`, 6: ALU opcode width; taken from `rx_data[NBIT_OP-1:0]`.
- `TIMEOUT_TICKS`, 40000000: inter-byte timeout in `CLK` cycles. Only used with `UART_ALU_CTRL_TIMEOUT_EN`.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_done_tick`  in  1  one-cycle pulse from RX; `rx_data` is valid in the same cycle.
- `rx_data`  in  NBIT_DATA  received byte.
- `tx_done_tick`  in  1  one-cycle pulse from TX at the end of the stop bit.
- `alu_result`  in  NBIT_DATA  combinational ALU output.
- `alu_a`, `alu_b`  out  NBIT_DATA  registered operands.
- `alu_op`  out  NBIT_OP  registered opcode.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_data`  out  NBIT_DATA  registered result byte; stable from `tx_start` until `tx_done_tick`.
- `busy`  out  1  high in states EXEC, SEND and WAIT_TX.
- `overrun`  out  1  one-cycle pulse when a byte arrives while `busy`.
- `timeout`  out  1  one-cycle pulse when a partial frame is aborted.

## Operation
States: WAIT_A → WAIT_B → WAIT_OP → EXEC → SEND → WAIT_TX → WAIT_A.
- WAIT_A: on `rx_done_tick`, `alu_a <= rx_data`; go to WAIT_B.
- WAIT_B: on `rx_done_tick`, `alu_b <= rx_data`; go to WAIT_OP.
- WAIT_OP: on `rx_done_tick`, `alu_op <= rx_data[NBIT_OP-1:0]`; go to EXEC. The upper `rx_data` bits are discarded.
- EXEC: `tx_data <= alu_result`; go to SEND. This gives the ALU one full cycle of settled, registered inputs.
- SEND: `tx_start = 1` for exactly this cycle; go to WAIT_TX.
- WAIT_TX: on `tx_done_tick`, go to WAIT_A. `alu_a`, `alu_b` and `alu_op` hold their values until they are overwritten.
- A `tx_done_tick` seen in any state other than WAIT_TX is ignored.
- An `rx_done_tick` in EXEC, SEND or WAIT_TX:
  - the byte is dropped;
  - `overrun` pulses in the next cycle;
  - the state is unaffected.
- `reset` asserted in any state, including mid-frame or mid-transmission, forces the state to WAIT_A on the next edge. Any partial frame is discarded.

## Timing
- Reset values: state WAIT_A; `alu_a`, `alu_b`, `alu_op`, `tx_data` = 0; `tx_start`, `busy`, `overrun`, `timeout` = 0.
- `tx_start`, `overrun` and `timeout` are registered outputs. `busy` is decoded from the state register.
- Latency is fixed:
  - opcode `rx_done_tick` in cycle N;
  - EXEC in cycle N+1;
  - `tx_data` valid and `tx_start` high in cycle N+2.
- `busy` rises in cycle N+1. It falls one cycle after `tx_done_tick`.
- A new frame can start in the cycle immediately after WAIT_TX exits. The first byte is accepted if its `rx_done_tick` arrives in that cycle or later.

## Configuration
- With `UART_ALU_CTRL_TIMEOUT_EN` defined:
  - a counter clears on every accepted `rx_done_tick` and counts `CLK` cycles while in WAIT_B or WAIT_OP;
  - when it reaches `TIMEOUT_TICKS-1`, the state goes to WAIT_A and `timeout` pulses for one cycle;
  - the counter holds at 0 in all other states;
  - if a byte arrives in the same cycle as expiry, the byte wins: it is accepted and the counter clears.
- Without the macro: there is no counter, `timeout` is tied to 0, and a partial frame waits indefinitely.

## Structure
- Shared package `uart_pkg`:
  - state enum/localparams (3-bit encoding);
  - default `NBIT_DATA`/`NBIT_OP`;
  - the opcode constants used by the bench (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, XOR=6'h26, SRA=6'h03, SRL=6'h02, NOR=6'h27).
- One sub-module: `uart_ctrl_timeout`. It holds the counter, with clear/enable inputs and an expire output, and is instantiated only under `UART_ALU_CTRL_TIMEOUT_EN`.

## Test plan
- **Basic frame:** bytes 0x05, 0x03, 0x20 with an ALU model doing ADD → `alu_a`=0x05, `alu_b`=0x03, `alu_op`=0x20; `tx_data`=0x08; a single `tx_start` pulse 2 cycles after the third tick.
- **Back-to-back frames:** (0xF0, 0x0F, 0x25) then (0x10, 0x01, 0x22) with `tx_done_tick` between them → `tx_data` 0xFF then 0x0F; exactly 2 `tx_start` pulses.
- **Overrun:** a byte 0xAA arrives during WAIT_TX → `overrun` pulses once; the next frame 0x02, 0x02, 0x20 yields 0x04 (0xAA does not become operand A).
- **Reset mid-operation:** `reset` after operand B is accepted → all outputs return to 0; the next three bytes 0x01, 0x01, 0x20 form a complete frame → 0x02.
- **Timeout (macro on, `TIMEOUT_TICKS`=100):** byte 0x07, then silence → `timeout` pulses once after 100 idle cycles in WAIT_B; the next frame 0x09, 0x01, 0x22 → 0x08. With the macro off, the same silence produces no timeout.
- **Opcode truncation:** opcode byte 0xE0 → `alu_op`=0x20.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART/ALU sequencer.
// State encoding, default widths and ALU opcodes.
package uart_pkg;

   localparam int NBIT_DATA_DEF = 8;
   localparam int NBIT_OP_DEF   = 6;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_t;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_ctrl_timeout.sv
// Inter-byte timeout counter for the UART/ALU sequencer.
// Used only when UART_ALU_CTRL_TIMEOUT_EN is defined.
module uart_ctrl_timeout #(
   parameter int TICKS = 40000000
) (
   input  logic CLK,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int W = ($clog2(TICKS) > 0) ? $clog2(TICKS) : 1;
   localparam logic [W-1:0] LAST = W'(TICKS - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // a byte arriving on the expiry cycle clears, so it wins
   assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: RX bytes A, B, opcode -> ALU -> TX result.
// Optional inter-byte timeout: define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
   import uart_pkg::*;
#(
   parameter int NBIT_DATA     = NBIT_DATA_DEF,
   parameter int NBIT_OP       = NBIT_OP_DEF,
   parameter int TIMEOUT_TICKS = 40000000
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 rx_done_tick,
   input  logic [NBIT_DATA-1:0] rx_data,
   input  logic                 tx_done_tick,
   input  logic [NBIT_DATA-1:0] alu_result,
   output logic [NBIT_DATA-1:0] alu_a,
   output logic [NBIT_DATA-1:0] alu_b,
   output logic [NBIT_OP-1:0]   alu_op,
   output logic                 tx_start,
   output logic [NBIT_DATA-1:0] tx_data,
   output logic                 busy,
   output logic                 overrun,
   output logic                 timeout
);

   state_t state;
   logic   expire;

   assign busy = (state == ST_EXEC) || (state == ST_SEND) ||
                 (state == ST_WAIT_TX);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   logic tmo_en;
   logic tmo_clr;

   assign tmo_en  = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
   assign tmo_clr = rx_done_tick || !tmo_en;

   uart_ctrl_timeout #(
      .TICKS (TIMEOUT_TICKS)
   ) u_timeout (
      .CLK    (CLK),
      .reset  (reset),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expire (expire)
   );
`else
   // partial frames never expire
   assign expire = 1'b0 & (TIMEOUT_TICKS != 0);
`endif

   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= ST_WAIT_A;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         overrun  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         timeout  <= 1'b0;
         overrun  <= rx_done_tick && busy;
         case (state)
            ST_WAIT_A: begin
               if (rx_done_tick) begin
                  alu_a <= rx_data;
                  state <= ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               if (rx_done_tick) begin
                  alu_b <= rx_data;
                  state <= ST_WAIT_OP;
               end else if (expire) begin
                  state   <= ST_WAIT_A;
                  timeout <= 1'b1;
               end
            end
            ST_WAIT_OP: begin
               if (rx_done_tick) begin
                  alu_op <= rx_data[NBIT_OP-1:0];
                  state  <= ST_EXEC;
               end else if (expire) begin
                  state   <= ST_WAIT_A;
                  timeout <= 1'b1;
               end
            end
            // registered start lands in SEND together with tx_data
            ST_EXEC: begin
               tx_data  <= alu_result;
               tx_start <= 1'b1;
               state    <= ST_SEND;
            end
            ST_SEND: begin
               state <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (tx_done_tick) begin
                  state <= ST_WAIT_A;
               end
            end
            default: begin
               state <= ST_WAIT_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl with a behavioural ALU.
// Define UART_ALU_CTRL_TIMEOUT_EN to exercise the timeout path.
module tb_uart_alu_ctrl;
   import uart_pkg::*;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_done_tick = 1'b0;
   logic [7:0] alu_result;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       overrun;
   logic       timeout;

   int errors = 0;
   int checks = 0;
   int starts = 0;
   int ovr_cnt = 0;
   int tmo_cnt = 0;

   uart_alu_ctrl #(
      .NBIT_DATA     (8),
      .NBIT_OP       (6),
      .TIMEOUT_TICKS (100)
   ) dut (
      .CLK          (CLK),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .tx_done_tick (tx_done_tick),
      .alu_result   (alu_result),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .busy         (busy),
      .overrun      (overrun),
      .timeout      (timeout)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] alu_f(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [5:0] op);
      int sa;
      case (op)
         OP_ADD: return a + b;
         OP_SUB: return a - b;
         OP_AND: return a & b;
         OP_OR:  return a | b;
         OP_XOR: return a ^ b;
         OP_NOR: return ~(a | b);
         OP_SRL: return a >> b[2:0];
         OP_SRA: begin
            sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
            sa = sa / (1 << b[2:0]);
            if ((a >= 8'd128) && ((int'(a) % (1 << b[2:0])) != 0))
               sa = sa - 1;
            return 8'(sa);
         end
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result = alu_f(alu_a, alu_b, alu_op);

   always @(posedge CLK) begin
      if (tx_start) starts++;
      if (overrun) ovr_cnt++;
      if (timeout) tmo_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rx_byte(input logic [7:0] b);
      @(posedge CLK); #1;
      rx_done_tick = 1'b1;
      rx_data = b;
      @(posedge CLK); #1;
      rx_done_tick = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic tx_done();
      @(posedge CLK); #1;
      tx_done_tick = 1'b1;
      @(posedge CLK); #1;
      tx_done_tick = 1'b0;
   endtask

   task automatic frame(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] opb,
                        input logic [7:0] exp, input bit inj_ovr);
      int s0;
      int o0;
      s0 = starts;
      o0 = ovr_cnt;
      rx_byte(a);
      rx_byte(b);
      rx_byte(opb);
      @(negedge CLK);
      chk({tag, ".busy_exec"}, busy, 1);
      chk({tag, ".start_early"}, tx_start, 0);
      chk({tag, ".alu_a"}, alu_a, a);
      chk({tag, ".alu_b"}, alu_b, b);
      chk({tag, ".alu_op"}, alu_op, opb & 8'h3F);
      @(negedge CLK);
      chk({tag, ".tx_start"}, tx_start, 1);
      chk({tag, ".tx_data"}, tx_data, exp);
      @(negedge CLK);
      chk({tag, ".start_once"}, tx_start, 0);
      if (inj_ovr) begin
         rx_byte(8'hAA);
         @(negedge CLK);
         chk({tag, ".overrun"}, overrun, 1);
         @(negedge CLK);
         chk({tag, ".overrun_end"}, overrun, 0);
         chk({tag, ".ovr_count"}, ovr_cnt - o0, 1);
         chk({tag, ".busy_after_ovr"}, busy, 1);
      end
      repeat (2) @(negedge CLK);
      chk({tag, ".busy_wait_tx"}, busy, 1);
      tx_done();
      @(negedge CLK);
      chk({tag, ".busy_done"}, busy, 0);
      chk({tag, ".tx_data_hold"}, tx_data, exp);
      chk({tag, ".start_count"}, starts - s0, 1);
   endtask

   initial begin : main
      logic [5:0] ops [8];
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] ro;
      int t0;

      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
              OP_XOR, OP_SRA, OP_SRL, OP_NOR};

      repeat (3) @(posedge CLK);
      #1 reset = 1'b0;
      @(negedge CLK);
      chk("rst.alu_a", alu_a, 0);
      chk("rst.alu_b", alu_b, 0);
      chk("rst.alu_op", alu_op, 0);
      chk("rst.tx_data", tx_data, 0);
      chk("rst.flags", {tx_start, busy, overrun, timeout}, 0);

      // stray tx_done outside WAIT_TX must be ignored
      tx_done();
      frame("basic", 8'h05, 8'h03, 8'h20, 8'h08, 0);
      frame("b2b1", 8'hF0, 8'h0F, 8'h25, 8'hFF, 0);
      frame("b2b2", 8'h10, 8'h01, 8'h22, 8'h0F, 0);
      frame("ovr", 8'h11, 8'h22, 8'h24, 8'h00, 1);
      frame("post_ovr", 8'h02, 8'h02, 8'h20, 8'h04, 0);

      rx_byte(8'h33);
      rx_byte(8'h44);
      @(posedge CLK); #1 reset = 1'b1;
      @(posedge CLK); #1 reset = 1'b0;
      @(negedge CLK);
      chk("rmid.alu_a", alu_a, 0);
      chk("rmid.alu_b", alu_b, 0);
      chk("rmid.alu_op", alu_op, 0);
      chk("rmid.tx_data", tx_data, 0);
      chk("rmid.flags", {tx_start, busy, overrun, timeout}, 0);
      frame("after_rst", 8'h01, 8'h01, 8'h20, 8'h02, 0);

      frame("trunc", 8'h11, 8'h22, 8'hE0, 8'h33, 0);

      t0 = tmo_cnt;
      rx_byte(8'h07);
      repeat (150) @(negedge CLK);
`ifdef UART_ALU_CTRL_TIMEOUT_EN
      chk("tmo.count", tmo_cnt - t0, 1);
      chk("tmo.busy", busy, 0);
      frame("tmo_next", 8'h09, 8'h01, 8'h22, 8'h08, 0);
`else
      chk("tmo.count", tmo_cnt - t0, 0);
      rx_byte(8'h01);
      rx_byte(8'h22);
      @(negedge CLK);
      chk("notmo.alu_a", alu_a, 8'h07);
      @(negedge CLK);
      chk("notmo.tx_data", tx_data, 8'h06);
      chk("notmo.tx_start", tx_start, 1);
      repeat (2) @(negedge CLK);
      tx_done();
      @(negedge CLK);
      chk("notmo.busy", busy, 0);
`endif

      for (int i = 0; i < 10; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         ro = {2'($urandom), ops[$urandom_range(0, 7)]};
         frame($sformatf("rnd%0d", i), ra, rb, ro,
               alu_f(ra, rb, ro[5:0]), 0);
      end

      chk("total_overrun", ovr_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
